bank_row_sequencer: RTL and testbench

//  Read sequencer for the 8-bank row memory that feeds the matrix buffer.
//  On start it issues a run of row addresses, broadcast to all banks, with wrap-around.
//  It tracks the fixed BRAM read latency and captures each returned bank-row into a small FIFO.
//  It streams rows out on a valid/ready interface with backpressure and loses no reads.
//  It sits between the single-port read-first BRAM banks and the matrix buffer/consumer.

---
 rtl/bank_row_sequencer.sv | 172 +++++++++++++++++
 tb/tb_bank_row_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_row_sequencer.sv
// Row read sequencer for the banked row memory: issues wrapped row addresses, tracks BRAM
// latency with a tag pipe and streams captured rows out of a fall-through FIFO.
module bank_row_sequencer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 8,
  parameter int unsigned BANK_NUM   = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int unsigned CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [ADDR_WIDTH-1:0]          base_row,
  input  logic [CNT_WIDTH-1:0]           num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [BANK_NUM*ADDR_WIDTH-1:0] addr_row_o,
  input  logic [BANK_NUM*DATA_WIDTH-1:0] mem_row_i,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BANK_NUM*DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]          out_row_idx,
  output logic                           out_last
);

  localparam int unsigned PipeDepth = RD_LATENCY + 1;
  localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCntW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned InfW      = $clog2(PipeDepth + 1);
  localparam int unsigned RowW      = BANK_NUM * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] addr_q, row_q;
  logic [CNT_WIDTH-1:0]  total_q, issued_q;
  logic [PipeDepth-1:0]  pipe_vld_q, pipe_last_q;
  logic [ADDR_WIDTH-1:0] pipe_row_q [PipeDepth];

  logic [RowW-1:0]       fifo_data_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_row_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [FCntW-1:0]      fifo_cnt_q;

  logic [InfW-1:0]       inflight;
  logic                  pop, capture, can_issue, issue_last;
  logic [ADDR_WIDTH-1:0] row_next;
  logic [CNT_WIDTH-1:0]  num_clip;
  logic [PtrW-1:0]       wr_ptr_next, rd_ptr_next;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(PipeDepth); i++) inflight = inflight + InfW'(pipe_vld_q[i]);
  end

  assign out_valid   = (fifo_cnt_q != '0);
  assign pop         = out_valid & out_ready;
  assign capture     = pipe_vld_q[PipeDepth-1];
  // A pop on this edge frees a slot, so it counts as credit; this keeps one row per cycle.
  assign can_issue   = (state_q == StIssue) &&
                       (32'(fifo_cnt_q) + 32'(inflight) < FIFO_DEPTH + 32'(pop));
  assign issue_last  = (issued_q == total_q - CNT_WIDTH'(1));
  assign row_next    = (32'(row_q) == MEM_DEPTH - 1) ? '0 : row_q + ADDR_WIDTH'(1);
  assign num_clip    = (32'(num_rows) > MEM_DEPTH) ? CNT_WIDTH'(MEM_DEPTH) : num_rows;
  assign wr_ptr_next = (32'(wr_ptr_q) == FIFO_DEPTH - 1) ? '0 : wr_ptr_q + PtrW'(1);
  assign rd_ptr_next = (32'(rd_ptr_q) == FIFO_DEPTH - 1) ? '0 : rd_ptr_q + PtrW'(1);

  assign busy        = busy_q;
  assign done        = done_q;
  assign addr_row_o  = {BANK_NUM{addr_q}};
  assign out_data    = fifo_data_q[rd_ptr_q];
  assign out_row_idx = fifo_row_q[rd_ptr_q];
  assign out_last    = fifo_last_q[rd_ptr_q];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      row_q       <= '0;
      total_q     <= '0;
      issued_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < int'(PipeDepth); i++) pipe_row_q[i] <= '0;
    end else if (abort) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      issued_q   <= '0;
      pipe_vld_q <= '0;
    end else begin
      done_q        <= 1'b0;
      pipe_vld_q    <= {pipe_vld_q[PipeDepth-2:0], can_issue};
      pipe_last_q   <= {pipe_last_q[PipeDepth-2:0], issue_last};
      pipe_row_q[0] <= row_q;
      for (int i = 1; i < int'(PipeDepth); i++) pipe_row_q[i] <= pipe_row_q[i-1];
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              row_q    <= base_row;
              total_q  <= num_clip;
              issued_q <= '0;
              busy_q   <= 1'b1;
              state_q  <= StIssue;
            end
          end
        end
        StIssue: begin
          if (can_issue) begin
            addr_q   <= row_q;
            row_q    <= row_next;
            issued_q <= issued_q + CNT_WIDTH'(1);
            if (issue_last) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (inflight == '0 && fifo_cnt_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      fifo_last_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_row_q[i]  <= '0;
      end
    end else if (abort) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (capture) begin
        fifo_data_q[wr_ptr_q] <= mem_row_i;
        fifo_row_q[wr_ptr_q]  <= pipe_row_q[PipeDepth-1];
        fifo_last_q[wr_ptr_q] <= pipe_last_q[PipeDepth-1];
        wr_ptr_q              <= wr_ptr_next;
      end
      if (pop) rd_ptr_q <= rd_ptr_next;
      unique case ({capture, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // The issue credit guarantees room for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (!nrst)
    !(capture && !abort && !pop && (32'(fifo_cnt_q) == FIFO_DEPTH)));

endmodule

// File: tb/tb_bank_row_sequencer.sv
// Bench for bank_row_sequencer: read-first BRAM model with output register, and a scoreboard
// of expected rows pushed at start and popped on every accepted output row.
module tb_bank_row_sequencer;

  localparam int DW = 8;
  localparam int MD = 8;
  localparam int BN = 8;
  localparam int RL = 2;
  localparam int FD = 4;
  localparam int AW = 3;
  localparam int CW = 4;

  typedef logic [AW+BN*DW:0] sb_t;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [AW-1:0]     base_row = '0;
  logic [CW-1:0]     num_rows = '0;
  logic              busy, done;
  logic [BN*AW-1:0]  addr_row_o;
  logic [BN*DW-1:0]  mem_row_i = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [BN*DW-1:0]  out_data;
  logic [AW-1:0]     out_row_idx;
  logic              out_last;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  int hs_count = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int start_cyc = 0;
  int done_cyc = 0;
  sb_t exp_q[$];
  logic [BN*DW-1:0] rd_stage = '0;

  bank_row_sequencer #(
    .DATA_WIDTH(DW), .MEM_DEPTH(MD), .BANK_NUM(BN), .RD_LATENCY(RL), .FIFO_DEPTH(FD),
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort), .base_row(base_row),
    .num_rows(num_rows), .busy(busy), .done(done), .addr_row_o(addr_row_o),
    .mem_row_i(mem_row_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row_idx(out_row_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] word(input int b, input int r);
    return DW'((r * 16 + b * 3) ^ 90);
  endfunction

  function automatic logic [BN*DW-1:0] row_word(input int r);
    logic [BN*DW-1:0] w;
    for (int b = 0; b < BN; b++) w[b*DW +: DW] = word(b, r);
    return w;
  endfunction

  // Each bank reads its own address slice; two register stages give RD_LATENCY = 2.
  always @(posedge clk) begin
    for (int b = 0; b < BN; b++) rd_stage[b*DW +: DW] <= word(b, int'(addr_row_o[b*AW +: AW]));
    mem_row_i <= rd_stage;
  end

  always @(negedge clk) begin
    if (nrst && out_valid && out_ready) begin
      sb_t got, want;
      got = {out_row_idx, out_last, out_data};
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_row: got row=%0d last=%0b, want no row", out_row_idx, out_last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_row: got row=%0d last=%0b data=%h, want row=%0d last=%0b data=%h",
                   out_row_idx, out_last, out_data, want[AW+BN*DW:BN*DW+1], want[BN*DW],
                   want[BN*DW-1:0]);
        end
      end
      if (hs_count == 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
      hs_count++;
    end
  end

  task automatic expect_run(input int base, input int num);
    int n;
    n = (num > MD) ? MD : num;
    for (int i = 0; i < n; i++) begin
      int r;
      r = (base + i) % MD;
      exp_q.push_back({AW'(r), (i == n - 1), row_word(r)});
    end
  endtask

  task automatic kick(input int base, input int num);
    expect_run(base, num);
    hs_count = 0;
    first_hs_cyc = -1;
    last_hs_cyc = -1;
    @(posedge clk); #1;
    base_row = AW'(base);
    num_rows = CW'(num);
    start = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/done/valid=%b, want 000", {busy, done, out_valid});
    end
    vectors++;
    if (addr_row_o !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %h, want 0", addr_row_o);
    end
    vectors++;
    if ({out_data, out_row_idx, out_last} !== '0) begin
      errors++;
      $display("FAIL reset_data: got data=%h row=%0d last=%0b, want 0", out_data, out_row_idx,
               out_last);
    end
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({busy, done, out_valid, addr_row_o} !== '0) begin
        errors++;
        $display("FAIL idle_quiet: got busy=%0b done=%0b valid=%0b addr=%h, want all 0", busy,
                 done, out_valid, addr_row_o);
      end
    end
  endtask

  task automatic test_basic;
    bit seen;
    out_ready = 1'b1;
    kick(0, 8);
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b, want 1", busy);
    end
    wait_done(60, seen);
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL basic_done_timeout: got no done, want done within 60 cycles");
    end
    vectors++;
    if (hs_count !== 8) begin
      errors++;
      $display("FAIL basic_count: got %0d rows, want 8", hs_count);
    end
    vectors++;
    if (first_hs_cyc - start_cyc !== 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 4", first_hs_cyc - start_cyc);
    end
    vectors++;
    if (last_hs_cyc - first_hs_cyc !== 7) begin
      errors++;
      $display("FAIL basic_rate: got span %0d, want 7", last_hs_cyc - first_hs_cyc);
    end
    vectors++;
    if (done_cyc !== last_hs_cyc + 2) begin
      errors++;
      $display("FAIL basic_done_time: got cycle %0d, want %0d", done_cyc, last_hs_cyc + 2);
    end
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_end_state: got busy/valid=%b, want 00", {busy, out_valid});
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: got %b, want 0", done);
    end
    vectors++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL basic_left: got %0d rows pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap;
    bit seen;
    kick(6, 4);
    wait_done(60, seen);
    vectors++;
    if (!seen || hs_count !== 4 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL wrap_run: got done=%0b rows=%0d pending=%0d, want 1/4/0", seen, hs_count,
               exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    bit seen;
    bit got_valid;
    int drops;
    logic [BN*AW-1:0] want_addr;
    out_ready = 1'b0;
    kick(0, 8);
    got_valid = 1'b0;
    for (int i = 0; i < 20 && !got_valid; i++) begin
      @(negedge clk);
      got_valid = out_valid;
    end
    vectors++;
    if (!got_valid) begin
      errors++;
      $display("FAIL bp_first_valid: got none, want out_valid within 20 cycles");
    end
    drops = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1) drops++;
    end
    vectors++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL bp_hold_valid: got %0d low cycles, want 0", drops);
    end
    want_addr = {BN{AW'(FD - 1)}};
    vectors++;
    if (addr_row_o !== want_addr) begin
      errors++;
      $display("FAIL bp_stall_addr: got %h, want %h", addr_row_o, want_addr);
    end
    vectors++;
    if (hs_count !== 0) begin
      errors++;
      $display("FAIL bp_no_accept: got %0d rows, want 0", hs_count);
    end
    out_ready = 1'b1;
    wait_done(60, seen);
    vectors++;
    if (!seen || hs_count !== 8 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_resume: got done=%0b rows=%0d pending=%0d, want 1/8/0", seen, hs_count,
               exp_q.size());
    end
  endtask

  task automatic test_count_edges;
    bit seen;
    int bad;
    kick(0, 0);
    vectors++;
    if ({done, busy} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done: got done/busy=%b, want 10", {done, busy});
    end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: got %b, want 0", done);
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL zero_quiet: got %0d active cycles, want 0", bad);
    end
    kick(3, 12);
    repeat (3) @(posedge clk);
    #1;
    base_row = 3'd5;
    num_rows = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(80, seen);
    vectors++;
    if (!seen || hs_count !== 8 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL clip_run: got done=%0b rows=%0d pending=%0d, want 1/8/0", seen, hs_count,
               exp_q.size());
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_abort;
    bit seen;
    int bad;
    int k;
    out_ready = 1'b1;
    kick(0, 8);
    for (k = 0; k < 30 && hs_count < 3; k++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (hs_count !== 3) begin
      errors++;
      $display("FAIL abort_reach: got %0d rows, want 3", hs_count);
    end
    abort = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if ({out_valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL abort_flush: got valid/busy/done=%b, want 000", {out_valid, busy, done});
    end
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0 || hs_count !== 3) begin
      errors++;
      $display("FAIL abort_quiet: got %0d active cycles, %0d rows, want 0 and 3", bad, hs_count);
    end
    exp_q.delete();
    kick(2, 2);
    wait_done(40, seen);
    vectors++;
    if (!seen || hs_count !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_restart: got done=%0b rows=%0d pending=%0d, want 1/2/0", seen,
               hs_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    int k;
    kick(0, 8);
    for (k = 0; k < 30 && hs_count < 2; k++) begin
      @(posedge clk); #1;
    end
    nrst = 1'b0;
    #1;
    vectors++;
    if ({busy, done, out_valid, addr_row_o, out_data} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%0b done=%0b valid=%0b addr=%h data=%h, want all 0",
               busy, done, out_valid, addr_row_o, out_data);
    end
    #1;
    nrst = 1'b1;
    exp_q.delete();
    kick(2, 2);
    wait_done(40, seen);
    vectors++;
    if (!seen || hs_count !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL reset_restart: got done=%0b rows=%0d pending=%0d, want 1/2/0", seen,
               hs_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_count_edges;
    test_abort;
    test_reset_mid;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000 time units");
    $fatal(1, "bench timed out");
  end

endmodule
